// File: rtl/ldpc_mem_rd_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_mem_rd_arb_if
// Purpose  : Request, read-return and write bus for the ldpc_mem_rd_arb arbiter
// Revision : 1.0  initial release
// ============================================================================
interface ldpc_mem_rd_arb_if #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8,
    parameter int pREQ_N  = 2
);
    localparam int c_ID_W = $clog2(pREQ_N);

    logic [pREQ_N-1:0]         ireq;
    logic [pREQ_N*pADDR_W-1:0] ibase;
    logic [pREQ_N-1:0]         ogrant;
    logic [pREQ_N-1:0]         odone;
    logic [pADDR_W-1:0]        omem_raddr;
    logic [pDAT_W-1:0]         imem_rdat;
    logic [pDAT_W-1:0]         ordat;
    logic                      orval;
    logic [c_ID_W-1:0]         orid;
    logic                      iwrite;
    logic [pADDR_W-1:0]        iwaddr;
    logic [pDAT_W-1:0]         iwdat;

    // arbiter side
    modport slave (
        input  ireq, ibase, imem_rdat, iwrite, iwaddr, iwdat,
        output ogrant, odone, omem_raddr, ordat, orval, orid
    );

    // requesters + RAM side
    modport master (
        output ireq, ibase, imem_rdat, iwrite, iwaddr, iwdat,
        input  ogrant, odone, omem_raddr, ordat, orval, orid
    );
endinterface
`default_nettype wire

// File: rtl/ldpc_mem_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_mem_rd_arb
// Purpose  : Round-robin read-port arbiter and burst sequencer for one
//            ldpc_mem_block RAM; 2-cycle read latency tracked for orval/orid.
//            Optional read-after-write forwarding: LDPC_MEM_RD_ARB_FWD_EN
// Revision : 1.0  initial release
// ============================================================================
module ldpc_mem_rd_arb #(
    parameter int pADDR_W    = 8,
    parameter int pDAT_W     = 8,
    parameter int pREQ_N     = 2,
    parameter int pBURST_LEN = 16
) (
    input  wire logic            iclk,
    input  wire logic            ireset,
    input  wire logic            iclkena,
    ldpc_mem_rd_arb_if.slave     bus
);
    localparam int c_ID_W  = $clog2(pREQ_N);
    localparam int c_CNT_W = (pBURST_LEN > 1) ? $clog2(pBURST_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(pBURST_LEN - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [pREQ_N-1:0]   r_grant, w_grant_nxt;
    logic [pADDR_W-1:0]  r_raddr, w_raddr_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [c_ID_W-1:0]   r_rr, w_rr_nxt;
    logic [c_ID_W-1:0]   r_owner, w_owner_nxt;
    logic [pREQ_N-1:0]   w_done;
    logic                w_found;
    logic [c_ID_W-1:0]   w_win;
    logic                w_issue;

    // read-latency pipeline: stage 1 aligns with the RAM address register
    logic                r_v1, r_v2;
    logic [c_ID_W-1:0]   r_id1, r_id2;

    // first requesting unit at or above the rr pointer, wrapping
    always_comb begin : p_pick
        logic [c_ID_W-1:0] v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = '0;
        for (int i = 0; i < pREQ_N; i++) begin
            v_idx = c_ID_W'((int'(r_rr) + i) % pREQ_N);
            if (!w_found && bus.ireq[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_raddr_nxt = r_raddr;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;
        w_owner_nxt = r_owner;
        w_done      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt        = S_BURST;
                    w_grant_nxt        = '0;
                    w_grant_nxt[w_win] = 1'b1;
                    w_raddr_nxt        = bus.ibase[int'(w_win)*pADDR_W +: pADDR_W];
                    w_cnt_nxt          = '0;
                    w_owner_nxt        = w_win;
                end
            end
            S_BURST: begin
                if (r_cnt == c_LAST) begin
                    w_done      = r_grant;
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = (r_owner == c_ID_W'(pREQ_N - 1)) ? '0 : r_owner + 1'b1;
                end else begin
                    w_raddr_nxt = r_raddr + 1'b1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_raddr <= '0;
            r_cnt   <= '0;
            r_rr    <= '0;
            r_owner <= '0;
        end else if (iclkena) begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_raddr <= w_raddr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rr    <= w_rr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign w_issue = (r_state == S_BURST);

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_id1 <= '0;
            r_id2 <= '0;
        end else if (iclkena) begin
            r_v1  <= w_issue;
            r_id1 <= r_owner;
            r_v2  <= r_v1;
            r_id2 <= r_id1;
        end
    end

    assign bus.ogrant     = r_grant;
    assign bus.odone      = w_done;
    assign bus.omem_raddr = r_raddr;
    assign bus.orval      = r_v2;
    assign bus.orid       = r_id2;

`ifdef LDPC_MEM_RD_ARB_FWD_EN
    logic [pADDR_W-1:0] r_a1;
    logic               r_h1, r_h2;
    logic [pDAT_W-1:0]  r_d1, r_d2;
    logic               w_hit_iss, w_hit_s1;

    // a write hitting a read still in flight supersedes the RAM's old data
    assign w_hit_iss = bus.iwrite && w_issue && (bus.iwaddr == r_raddr);
    assign w_hit_s1  = bus.iwrite && r_v1 && (bus.iwaddr == r_a1);

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_a1 <= '0;
            r_h1 <= 1'b0;
            r_d1 <= '0;
            r_h2 <= 1'b0;
            r_d2 <= '0;
        end else if (iclkena) begin
            r_a1 <= r_raddr;
            r_h1 <= w_hit_iss;
            r_d1 <= bus.iwdat;
            if (w_hit_s1) begin
                r_h2 <= 1'b1;
                r_d2 <= bus.iwdat;
            end else begin
                r_h2 <= r_h1;
                r_d2 <= r_d1;
            end
        end
    end

    assign bus.ordat = r_h2 ? r_d2 : bus.imem_rdat;
`else
    logic w_unused_wr;
    assign w_unused_wr = ^{bus.iwrite, bus.iwaddr, bus.iwdat};
    assign bus.ordat   = bus.imem_rdat;
`endif

endmodule
`default_nettype wire

// File: doc/ldpc_mem_rd_arb.md
Name: ldpc_mem_rd_arb

Overview:
- Round-robin read-port arbiter and burst sequencer for one ldpc_mem_block simple dual-port RAM.
- Shares the RAM read port between pREQ_N decoder units (e.g. VNU/CNU engines).
- Each granted request is a fixed-length sequential burst from a base address.
- Returns read data tagged with requester id, with the RAM's 2-cycle pipelined latency accounted for. Write port passes straight through.

Parameters:
- pADDR_W, 8, RAM address width
- pDAT_W, 8, RAM data width
- pREQ_N, 2, number of read requesters (2..4)
- pBURST_LEN, 16, reads per burst (1..2**pADDR_W)

Ports:
- iclk  in  1  clock
- ireset  in  1  asynchronous active-low reset
- iclkena  in  1  clock enable; also drives the RAM iclkena
- ireq  in  pREQ_N  per-requester burst request, level, held until odone
- ibase  in  pREQ_N*pADDR_W  per-requester base address, stable while ireq high
- ogrant  out  pREQ_N  one-hot, current burst owner
- odone  out  pREQ_N  one-cycle pulse, last address of owner's burst issued
- omem_raddr  out  pADDR_W  RAM read address (registered)
- imem_rdat  in  pDAT_W  RAM read data
- ordat  out  pDAT_W  read data to requesters (= imem_rdat)
- orval  out  1  ordat valid
- orid  out  $clog2(pREQ_N)  requester id of ordat
- iwrite  in  1  write strobe, to RAM
- iwaddr  in  pADDR_W  write address, to RAM
- iwdat  in  pDAT_W  write data, to RAM

Behaviour:
- Reset, asynchronous, ireset=0:
  - state=IDLE; ogrant=0, odone=0, omem_raddr=0, orval=0, orid=0.
  - Round-robin pointer=0, burst counter=0.
- All state updates are gated by iclkena. With iclkena=0, every register holds, including the valid/id pipeline, so it stays aligned with the RAM.
- FSM IDLE:
  - If any ireq bit is set, pick the first set bit scanning from the rr pointer upward, with wrap.
  - Next cycle: ogrant=one-hot(winner), omem_raddr=ibase[winner], counter=0, state=BURST.
- FSM BURST:
  - Each enabled cycle issues one read: omem_raddr increments modulo 2**pADDR_W (wraps FF..->00), counter increments.
  - On the cycle issuing read pBURST_LEN-1, odone[owner]=1 for that cycle.
  - Next cycle: ogrant=0, rr pointer=owner+1 mod pREQ_N, state=IDLE.
  - ireq dropping mid-burst is ignored; the burst completes.
- Back-to-back bursts insert one IDLE cycle.
- Issue flag and id enter a 2-stage pipeline that tracks the RAM latency:
  - orval/orid assert exactly 2 enabled cycles after the matching omem_raddr cycle.
  - ordat = imem_rdat, combinational passthrough.
- Single requester repeatedly asserting ireq gets consecutive bursts; fairness applies only among simultaneous requesters.
- Write port is a pure wire passthrough with no arbitration.
- Same-cycle write/read to the same address returns old RAM data unless the optional feature is compiled in.
- Reset mid-burst aborts immediately. In-flight orval are dropped; the RAM contents are not touched.

Optional Feature:
- Macro LDPC_MEM_RD_ARB_FWD_EN.
- Defined:
  - Compare iwaddr against omem_raddr each enabled cycle with iwrite=1.
  - On a match, pipe a hit flag and iwdat alongside the valid pipeline.
  - When hit arrives with orval, ordat=forwarded iwdat instead of imem_rdat.
  - Also compare the write against each of the 2 reads in flight; a later matching write overrides the stored data. Result: read-after-write coherent.
- Undefined: no comparators; ordat always = imem_rdat (old-data semantics).

Test Plan:
- Single burst: ireq=01, ibase[0]=8'h10, pBURST_LEN=4 -> omem_raddr 10,11,12,13. odone[0] with 13. orval 4 cycles, orid=0, ordat=mem[10..13].
- Contention: ireq=11 held, rr=0 -> grants 0,1,0,1 alternate. One IDLE cycle between bursts; orid sequence matches grants.
- Wrap: ibase[1]=8'hFE, pBURST_LEN=4 -> addresses FE,FF,00,01; data correct.
- Clock enable: toggle iclkena 0/1 every cycle during a burst -> addresses and orval advance only on enabled cycles; data/id alignment preserved.
- Async reset: assert ireset=0 at read 2 of a burst -> outputs 0 immediately, orval never rises for in-flight reads. After release, a new ireq is served starting at rr=0.
- FWD_EN: write 8'hAA to 8'h11 in the same cycle as read 11 issues (old 8'h55) -> ordat=AA with the macro, 55 without.
